// File: rtl/univ_shift_scan_pkg.sv
// univ_shift_scan_pkg: shared op encodings, FSM states and the gfedcba hex segment table (active-high)
package univ_shift_scan_pkg;
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/univ_shift_scan_hex_to_seg.sv
// hex_to_seg: combinational nibble (i_nib) to active-high gfedcba segments (o_seg)
module hex_to_seg
  import univ_shift_scan_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_TAB[i_nib];
endmodule

// File: rtl/univ_shift_scan.sv
// univ_shift_scan: repeat-count universal shift register (op/load_val/count/start in; busy/done/q/sout out) with multiplexed hex display (seg/dig_sel)
module univ_shift_scan
  import univ_shift_scan_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 4,
  parameter int SCAN_DIV    = 50000,
  parameter bit SEG_ACT_LOW = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         op,
  input  logic               sin_l,
  input  logic               sin_r,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [CNT_W-1:0]   count,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   q,
  output logic               sout_l,
  output logic               sout_r,
  output logic [6:0]         seg,
  output logic [WIDTH/4-1:0] dig_sel
);
  localparam int ND = WIDTH / 4;
  localparam int IW = ND > 1 ? $clog2(ND) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  state_t             r_state, w_next;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_load, r_q, w_shift;
  logic [CNT_W-1:0]   r_rem;
  logic [SW-1:0]      r_cnt;
  logic [IW-1:0]      r_idx;
  logic [3:0]         w_nib;
  logic [6:0]         w_seg;
  logic [ND-1:0]      w_dig;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? (|count ? S_RUN : S_DONE) : S_IDLE;
      S_RUN:   w_next = r_rem == CNT_W'(1) ? S_DONE : S_RUN;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    w_shift = r_q;
    case (r_op)
      OP_SHL:  w_shift = {r_q[WIDTH-2:0], sin_r};
      OP_SHR:  w_shift = {sin_l, r_q[WIDTH-1:1]};
      OP_LOAD: w_shift = r_load;
      OP_ROL:  w_shift = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      OP_ROR:  w_shift = {r_q[0], r_q[WIDTH-1:1]};
      OP_ASR:  w_shift = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      OP_CLR:  w_shift = '0;
      default: w_shift = r_q;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_load  <= '0;
      r_rem   <= '0;
      r_q     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_op   <= op;
        r_load <= load_val;
        r_rem  <= count;
      end
      if (r_state == S_RUN) begin
        r_q   <= w_shift;
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == SW'(SCAN_DIV - 1)) begin
      r_cnt <= '0;
      r_idx <= r_idx == IW'(ND - 1) ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + SW'(1);
    end
  end
  assign w_nib = r_q[{r_idx, 2'b00} +: 4];
  assign w_dig = ND'(1) << r_idx;
  hex_to_seg u_hex (.i_nib(w_nib), .o_seg(w_seg));
  assign seg     = SEG_ACT_LOW ? ~w_seg : w_seg;
  assign dig_sel = SEG_ACT_LOW ? ~w_dig : w_dig;
  assign busy    = r_state == S_RUN;
  assign done    = r_state == S_DONE;
  assign q       = r_q;
  assign sout_l  = r_q[WIDTH-1];
  assign sout_r  = r_q[0];
endmodule
